mem_line_serializer: RTL and testbench
======================================

Name: mem_line_serializer

Overview:
- Sits directly downstream of the L1D/L1I memory arbiter. Consumes its single cache-line memory port (mem_req_*, mem_rsp_*).
- Converts each line request into a sequence of narrow beat transactions on an external valid/ready memory bus.
- Collects the response beats and returns one full-line response pulse to the arbiter.
- Supports pipelined beat issue, with address issue decoupled from response collection.

Parameters:
- ADDR_W, 32, request address width (matches M_WIDTH).
- LG_CL_LEN, 4, log2 of line bytes; line bits CL_BITS = 8<<LG_CL_LEN = 128.
- BEAT_W, 32, bus data width; NBEATS = CL_BITS/BEAT_W = 4 (must be a power of 2, ≥2).
- TAG_W, 2, request tag width (LG_MEM_TAG_ENTRIES).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mem_req_valid  in  1  line request; level, held until mem_rsp_valid
- mem_req_addr  in  ADDR_W  line address
- mem_req_store_data  in  CL_BITS  store line
- mem_req_tag  in  TAG_W  request tag
- mem_req_opcode  in  4  MEM_LD_LINE / MEM_ST_LINE
- mem_rsp_valid  out  1  one-cycle response pulse
- mem_rsp_load_data  out  CL_BITS  loaded line
- mem_rsp_tag  out  TAG_W  echoed tag
- bus_req_valid  out  1  beat request
- bus_req_ready  in  1  bus accepts beat
- bus_req_we  out  1  1 = write beat
- bus_req_addr  out  ADDR_W  beat byte address
- bus_req_wdata  out  BEAT_W  write beat data
- bus_rsp_valid  in  1  in-order read data or write ack, one per accepted beat
- bus_rsp_rdata  in  BEAT_W  read beat data

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0, line buffer 0. Reset mid-transfer aborts immediately. Bus responses arriving after reset while in IDLE are ignored.
- States:
  - IDLE: if mem_req_valid, capture the request and go to ISSUE next cycle.
    - Captured fields: addr with low LG_CL_LEN bits forced 0, opcode, tag, store_data.
    - Unsupported opcode: go to RESP with zero data and no bus traffic.
  - ISSUE: bus_req_valid=1. Beat i has addr = base + i*(BEAT_W/8), wdata = store_data[i*BEAT_W +: BEAT_W], we = (opcode==MEM_ST_LINE).
    - Issue counter increments on valid&&ready.
    - After beat NBEATS-1 is accepted: go to DRAIN, or to RESP if all responses are already received.
  - DRAIN: bus_req_valid=0; wait until the response count reaches NBEATS, then go to RESP.
  - RESP: mem_rsp_valid=1 for exactly one cycle, mem_rsp_tag = captured tag; then IDLE.
- Response counter:
  - Increments on every bus_rsp_valid in ISSUE or DRAIN, including beats that complete while still issuing.
  - Loads write bus_rsp_rdata into line slice [cnt*BEAT_W +: BEAT_W].
  - Stores ignore rdata; mem_rsp_load_data is 0 for stores.
- Limits: the bus never returns a response in the same cycle as the beat's handshake. bus_rsp_valid in IDLE or RESP is dropped. Counters are log2(NBEATS)+1 bits wide; no wrap within a request.
- No combinational path from mem_req_valid to mem_rsp_valid. This is required because the arbiter drops mem_req_valid combinationally on mem_rsp_valid.
- mem_rsp_load_data holds its value until the next load completes.
- Latency with always-ready bus and 1-cycle response: request seen at cycle 0, beats issued at cycles 1–4, mem_rsp_valid at cycle 6, next request accepted at cycle 7.
- bus_req_addr/we/wdata are stable while bus_req_valid && !bus_req_ready.

Optional Feature:
- MEM_SER_PERF_EN defined: adds outputs perf_ld_lines[63:0], perf_st_lines[63:0] and perf_busy_cycles[63:0].
  - perf_ld_lines / perf_st_lines increment on the RESP cycle, by opcode.
  - perf_busy_cycles counts cycles where state != IDLE.
  - All three reset to 0 and saturate at all-ones.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_bus_pkg:
  - opcode constants MEM_LD_LINE=4'd4, MEM_ST_LINE=4'd7;
  - state enum ser_state_t {IDLE, ISSUE, DRAIN, RESP};
  - beat count localparam helpers.
- One natural sub-module: mem_beat_counter, an up-counter with clear and done flag, instantiated twice (issue and response).

Test Plan:
- Load at 0x1008, ready=1, rsp 1 cycle after handshake, rdata 0xA0,0xA1,0xA2,0xA3 -> beat addrs 0x1000,0x1004,0x1008,0x100C; mem_rsp_valid at cycle 6 with line 0x000000A3_000000A2_000000A1_000000A0.
- Store at 0x2000, data 0x44..._33..._22..._11..., tag 2 -> we=1, wdata 0x11,0x22,0x33,0x44 in order; after 4 acks a one-cycle rsp with tag 2 and data 0.
- Load with ready toggling 1,0,0,1,0,1,1 -> addr/wdata held during stalls; exactly 4 handshakes; single rsp pulse.
- Back-to-back: arbiter issues the next load the cycle after rsp -> accepted in IDLE; no duplicate capture of the first request.
- Reset asserted after 2 beats accepted -> next cycle all outputs 0, IDLE; stray bus_rsp_valid ignored; the following load completes correctly.
- MEM_SER_PERF_EN defined, 3 loads + 1 store -> perf_ld_lines=3, perf_st_lines=1, perf_busy_cycles equals the count of non-IDLE cycles.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared opcodes, serializer state encoding and line/beat sizing helpers
// for the memory line serializer.
package mem_bus_pkg;

  localparam logic [3:0] MEM_LD_LINE = 4'd4;
  localparam logic [3:0] MEM_ST_LINE = 4'd7;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_LG_CL_LEN = 4;
  localparam int DEF_BEAT_W    = 32;
  localparam int DEF_TAG_W     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } ser_state_t;

  function automatic int cl_bits(input int lg_cl_len);
    return 8 << lg_cl_len;
  endfunction

  function automatic int num_beats(input int lg_cl_len, input int beat_w);
    return cl_bits(lg_cl_len) / beat_w;
  endfunction

  // One extra bit so a counter can sit at NBEATS without wrapping.
  function automatic int beat_cnt_w(input int nbeats);
    return $clog2(nbeats) + 1;
  endfunction

endpackage

// File: rtl/mem_line_serializer_if.sv
// Line-side port (arbiter <-> serializer) and beat-side bus (serializer <-> memory).
// The master modport is the requesting side in both interfaces.
interface mem_line_if #(
  parameter int ADDR_W  = mem_bus_pkg::DEF_ADDR_W,
  parameter int CL_BITS = mem_bus_pkg::cl_bits(mem_bus_pkg::DEF_LG_CL_LEN),
  parameter int TAG_W   = mem_bus_pkg::DEF_TAG_W
);
  logic               mem_req_valid;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic [CL_BITS-1:0] mem_req_store_data;
  logic [TAG_W-1:0]   mem_req_tag;
  logic [3:0]         mem_req_opcode;
  logic               mem_rsp_valid;
  logic [CL_BITS-1:0] mem_rsp_load_data;
  logic [TAG_W-1:0]   mem_rsp_tag;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag, mem_req_opcode,
    input  mem_rsp_valid, mem_rsp_load_data, mem_rsp_tag
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag, mem_req_opcode,
    output mem_rsp_valid, mem_rsp_load_data, mem_rsp_tag
  );
endinterface

interface mem_bus_if #(
  parameter int ADDR_W = mem_bus_pkg::DEF_ADDR_W,
  parameter int BEAT_W = mem_bus_pkg::DEF_BEAT_W
);
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_we;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [BEAT_W-1:0] bus_req_wdata;
  logic              bus_rsp_valid;
  logic [BEAT_W-1:0] bus_rsp_rdata;

  modport master (
    output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );
endinterface

// File: rtl/mem_line_serializer_beat_counter.sv
// Saturating beat up-counter with synchronous clear; last_o flags N-1, done_o flags N.
module mem_beat_counter #(
  parameter int N = 4,
  parameter int W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign done_o = (cnt_q == W'(N));
  assign last_o = (cnt_q == W'(N - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !done_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_line_serializer.sv
// Splits one cache-line request into NBEATS bus beats and reassembles a single line response.
// Define MEM_SER_PERF_EN to add saturating perf counters (perf_ld_lines, perf_st_lines, perf_busy_cycles).
module mem_line_serializer
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LG_CL_LEN = DEF_LG_CL_LEN,
  parameter int BEAT_W    = DEF_BEAT_W,
  parameter int TAG_W     = DEF_TAG_W
) (
  input  logic      clk,
  input  logic      reset,
  mem_line_if.slave mem,
  mem_bus_if.master bus
`ifdef MEM_SER_PERF_EN
  ,
  output logic [63:0] perf_ld_lines,
  output logic [63:0] perf_st_lines,
  output logic [63:0] perf_busy_cycles
`endif
);

  localparam int CL_BITS    = cl_bits(LG_CL_LEN);
  localparam int NBEATS     = num_beats(LG_CL_LEN, BEAT_W);
  localparam int CNT_W      = beat_cnt_w(NBEATS);
  localparam int BEAT_SHIFT = $clog2(BEAT_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LG_CL_LEN) - 1);

  ser_state_t         state_q;
  logic [ADDR_W-1:0]  base_q;
  logic [3:0]         opcode_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CL_BITS-1:0] store_q;
  logic [CL_BITS-1:0] rsp_data_q;
  logic               rsp_valid_q;

  logic [BEAT_W-1:0]  store_beat [NBEATS];
  logic [CL_BITS-1:0] line_w;

  logic             capture, op_ok, is_ld, is_st;
  logic             iss_inc, iss_last, iss_done, last_accept;
  logic             rsp_inc, rsp_last, rsp_done, rsp_full;
  logic [CNT_W-1:0] iss_cnt, rsp_cnt;

  assign capture     = (state_q == IDLE) && mem.mem_req_valid;
  assign op_ok       = (mem.mem_req_opcode == MEM_LD_LINE) || (mem.mem_req_opcode == MEM_ST_LINE);
  assign is_ld       = (opcode_q == MEM_LD_LINE);
  assign is_st       = (opcode_q == MEM_ST_LINE);
  assign iss_inc     = (state_q == ISSUE) && bus.bus_req_ready && !iss_done;
  assign last_accept = iss_inc && iss_last;
  // Responses may overlap issue, so both ISSUE and DRAIN collect beats.
  assign rsp_inc     = ((state_q == ISSUE) || (state_q == DRAIN)) && bus.bus_rsp_valid && !rsp_done;
  assign rsp_full    = rsp_done || (rsp_inc && rsp_last);

  mem_beat_counter #(.N(NBEATS), .W(CNT_W)) u_iss_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (capture),
    .inc_i  (iss_inc),
    .cnt_o  (iss_cnt),
    .last_o (iss_last),
    .done_o (iss_done)
  );

  mem_beat_counter #(.N(NBEATS), .W(CNT_W)) u_rsp_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (capture),
    .inc_i  (rsp_inc),
    .cnt_o  (rsp_cnt),
    .last_o (rsp_last),
    .done_o (rsp_done)
  );

  for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
    logic [BEAT_W-1:0] beat_q;

    assign store_beat[gi]                = store_q[gi*BEAT_W +: BEAT_W];
    assign line_w[gi*BEAT_W +: BEAT_W]   = beat_q;

    always_ff @(posedge clk) begin
      if (reset || capture) begin
        beat_q <= '0;
      end else if (rsp_inc && is_ld && (rsp_cnt == CNT_W'(gi))) begin
        beat_q <= bus.bus_rsp_rdata;
      end
    end
  end

  // Address and data derive only from registers, so they stay put while the bus stalls.
  assign bus.bus_req_valid = (state_q == ISSUE);
  assign bus.bus_req_we    = (state_q == ISSUE) && is_st;
  assign bus.bus_req_addr  = base_q + (ADDR_W'(iss_cnt) << BEAT_SHIFT);
  assign bus.bus_req_wdata = iss_done ? '0 : store_beat[iss_cnt[CNT_W-2:0]];

  assign mem.mem_rsp_valid     = rsp_valid_q;
  assign mem.mem_rsp_tag       = tag_q;
  assign mem.mem_rsp_load_data = (state_q == RESP) ? (is_ld ? line_w : '0) : rsp_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      opcode_q    <= '0;
      tag_q       <= '0;
      store_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem.mem_req_valid) begin
            base_q   <= mem.mem_req_addr & LINE_MASK;
            opcode_q <= mem.mem_req_opcode;
            tag_q    <= mem.mem_req_tag;
            store_q  <= mem.mem_req_store_data;
            if (op_ok) begin
              state_q <= ISSUE;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (last_accept) begin
            if (rsp_full) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (rsp_full) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (is_ld) begin
            rsp_data_q <= line_w;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_SER_PERF_EN
  logic [63:0] perf_ld_q, perf_st_q, perf_busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ld_q   <= '0;
      perf_st_q   <= '0;
      perf_busy_q <= '0;
    end else begin
      if ((state_q == RESP) && is_ld && !(&perf_ld_q)) begin
        perf_ld_q <= perf_ld_q + 64'd1;
      end
      if ((state_q == RESP) && is_st && !(&perf_st_q)) begin
        perf_st_q <= perf_st_q + 64'd1;
      end
      if ((state_q != IDLE) && !(&perf_busy_q)) begin
        perf_busy_q <= perf_busy_q + 64'd1;
      end
    end
  end

  assign perf_ld_lines    = perf_ld_q;
  assign perf_st_lines    = perf_st_q;
  assign perf_busy_cycles = perf_busy_q;
`endif

endmodule

// File: tb/tb_mem_line_serializer.sv
// Scoreboard bench for mem_line_serializer: directed line requests, a 1-cycle-latency bus
// responder, and negedge monitors that pop expected beats and line responses.
module tb_mem_line_serializer;
  import mem_bus_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [1:0]   tag;
    logic [127:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_line_if #(.ADDR_W(32), .CL_BITS(128), .TAG_W(2)) mem_if ();
  mem_bus_if  #(.ADDR_W(32), .BEAT_W(32))              bus_if ();

`ifdef MEM_SER_PERF_EN
  logic [63:0] perf_ld, perf_st, perf_busy;
`endif

  mem_line_serializer #(.ADDR_W(32), .LG_CL_LEN(4), .BEAT_W(32), .TAG_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .mem   (mem_if),
    .bus   (bus_if)
`ifdef MEM_SER_PERF_EN
    ,
    .perf_ld_lines    (perf_ld),
    .perf_st_lines    (perf_st),
    .perf_busy_cycles (perf_busy)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_count = 0;
  int busy_exp = 0;
  int n_ld = 0;
  int n_st = 0;

  beat_t       exp_beats[$];
  rsp_t        exp_rsps[$];
  logic [31:0] rdata_q[$];
  bit          ready_pat[$];
  bit          stray_en = 1'b0;
  logic        pend_v = 1'b0;
  logic [31:0] pend_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus responder: one reply the cycle after each handshake.
  always @(negedge clk) begin
    if (bus_if.bus_req_valid && bus_if.bus_req_ready) begin
      pend_v = 1'b1;
      if (bus_if.bus_req_we) pend_d = 32'h0;
      else if (rdata_q.size() > 0) pend_d = rdata_q.pop_front();
      else pend_d = 32'hBAD0BAD0;
    end else begin
      pend_v = 1'b0;
    end
  end

  always @(posedge clk) begin
    #2;
    bus_if.bus_req_ready = (ready_pat.size() > 0) ? ready_pat.pop_front() : 1'b1;
    bus_if.bus_rsp_valid = pend_v || stray_en;
    bus_if.bus_rsp_rdata = pend_v ? pend_d : 32'hDEADBEEF;
  end

  // Monitor: beats, stall stability and line responses.
  logic        prev_stall = 1'b0, prev_rsp = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  always @(negedge clk) begin
    beat_t e;
    rsp_t  r;
    if (prev_stall)
      check(bus_if.bus_req_valid && bus_if.bus_req_addr == prev_addr && bus_if.bus_req_wdata == prev_wdata
            && bus_if.bus_req_we == prev_we, "stall_hold",
            {bus_if.bus_req_valid, bus_if.bus_req_we, bus_if.bus_req_addr, bus_if.bus_req_wdata},
            {1'b1, prev_we, prev_addr, prev_wdata});
    prev_stall = bus_if.bus_req_valid && !bus_if.bus_req_ready;
    prev_we    = bus_if.bus_req_we;
    prev_addr  = bus_if.bus_req_addr;
    prev_wdata = bus_if.bus_req_wdata;

    if (bus_if.bus_req_valid && bus_if.bus_req_ready) begin
      hs_count++;
      if (exp_beats.size() == 0) begin
        check(1'b0, "unexpected_beat", {bus_if.bus_req_we, bus_if.bus_req_addr, bus_if.bus_req_wdata}, 0);
      end else begin
        e = exp_beats.pop_front();
        check(bus_if.bus_req_we == e.we && bus_if.bus_req_addr == e.addr && bus_if.bus_req_wdata == e.wdata,
              "beat", {bus_if.bus_req_we, bus_if.bus_req_addr, bus_if.bus_req_wdata}, {e.we, e.addr, e.wdata});
      end
    end

    if (mem_if.mem_rsp_valid) begin
      check(!prev_rsp, "rsp_pulse", {127'd0, prev_rsp}, 0);
      if (exp_rsps.size() == 0) begin
        check(1'b0, "unexpected_rsp", mem_if.mem_rsp_load_data, 0);
      end else begin
        r = exp_rsps.pop_front();
        check(mem_if.mem_rsp_tag == r.tag, "rsp_tag", mem_if.mem_rsp_tag, r.tag);
        check(mem_if.mem_rsp_load_data == r.data, "rsp_data", mem_if.mem_rsp_load_data, r.data);
      end
    end
    prev_rsp = mem_if.mem_rsp_valid;
  end

  task automatic push_beats(input logic [31:0] base, input logic we, input logic [127:0] data);
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.we    = we;
      b.addr  = base + 32'(4 * i);
      b.wdata = data[i*32 +: 32];
      exp_beats.push_back(b);
    end
  endtask

  task automatic push_rdata(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
    rdata_q.push_back(w0);
    rdata_q.push_back(w1);
    rdata_q.push_back(w2);
    rdata_q.push_back(w3);
  endtask

  task automatic push_rsp(input logic [1:0] tag, input logic [127:0] data);
    rsp_t r;
    r.tag  = tag;
    r.data = data;
    exp_rsps.push_back(r);
  endtask

  // Called at posedge+1; returns at the posedge+1 after the response pulse.
  task automatic do_req(input logic [31:0] addr, input logic [3:0] op, input logic [1:0] tag,
                        input logic [127:0] data, output int lat);
    int c0;
    bit seen;
    mem_if.mem_req_valid      = 1'b1;
    mem_if.mem_req_addr       = addr;
    mem_if.mem_req_opcode     = op;
    mem_if.mem_req_tag        = tag;
    mem_if.mem_req_store_data = data;
    c0   = cyc;
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (mem_if.mem_rsp_valid) begin
        seen = 1'b1;
        lat  = cyc - c0;
      end
    end
    if (!seen) check(1'b0, "rsp_timeout", 0, 1);
    else begin
      busy_exp += lat;
      if (op == MEM_LD_LINE) n_ld++;
      if (op == MEM_ST_LINE) n_st++;
    end
    @(posedge clk);
    #1;
    mem_if.mem_req_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    int hs0;
    reset = 1'b1;
    mem_if.mem_req_valid      = 1'b0;
    mem_if.mem_req_addr       = '0;
    mem_if.mem_req_opcode     = '0;
    mem_if.mem_req_tag        = '0;
    mem_if.mem_req_store_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check({bus_if.bus_req_valid, bus_if.bus_req_we, bus_if.bus_req_addr, bus_if.bus_req_wdata,
           mem_if.mem_rsp_valid, mem_if.mem_rsp_tag} == 0 && mem_if.mem_rsp_load_data == 0, "reset_state",
          {bus_if.bus_req_valid, bus_if.bus_req_we, bus_if.bus_req_addr, bus_if.bus_req_wdata,
           mem_if.mem_rsp_valid, mem_if.mem_rsp_tag}, 0);

    // Reset after two accepted beats aborts the load.
    @(posedge clk);
    #1;
    push_beats(32'h6000, 1'b0, 128'h0);
    push_rdata(32'hE0, 32'hE1, 32'hE2, 32'hE3);
    mem_if.mem_req_valid  = 1'b1;
    mem_if.mem_req_addr   = 32'h6004;
    mem_if.mem_req_opcode = MEM_LD_LINE;
    mem_if.mem_req_tag    = 2'd2;
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge clk);
      if (bus_if.bus_req_valid && bus_if.bus_req_ready) n++;
    end
    check(n == 2, "abort_beats", n, 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_beats.delete();
    rdata_q.delete();
    mem_if.mem_req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check({bus_if.bus_req_valid, bus_if.bus_req_we, bus_if.bus_req_addr, bus_if.bus_req_wdata,
           mem_if.mem_rsp_valid, mem_if.mem_rsp_tag} == 0 && mem_if.mem_rsp_load_data == 0, "abort_outputs",
          {bus_if.bus_req_valid, bus_if.bus_req_we, bus_if.bus_req_addr, bus_if.bus_req_wdata,
           mem_if.mem_rsp_valid, mem_if.mem_rsp_tag}, 0);
    @(posedge clk);
    #1 stray_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 stray_en = 1'b0;

    push_beats(32'h7000, 1'b0, 128'h0);
    push_rdata(32'hF0, 32'hF1, 32'hF2, 32'hF3);
    push_rsp(2'd3, 128'h000000F3_000000F2_000000F1_000000F0);
    do_req(32'h7000, MEM_LD_LINE, 2'd3, 128'h0, lat);
    check(lat == 6, "lat_after_reset", lat, 6);

    push_beats(32'h1000, 1'b0, 128'h0);
    push_rdata(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    push_rsp(2'd1, 128'h000000A3_000000A2_000000A1_000000A0);
    do_req(32'h1008, MEM_LD_LINE, 2'd1, 128'h0, lat);
    check(lat == 6, "lat_load", lat, 6);

    push_beats(32'h2000, 1'b1, 128'h00000044_00000033_00000022_00000011);
    push_rsp(2'd2, 128'h0);
    do_req(32'h2000, MEM_ST_LINE, 2'd2, 128'h00000044_00000033_00000022_00000011, lat);
    check(lat == 6, "lat_store", lat, 6);

    // Leading entry covers the request cycle itself; the next seven cover ISSUE.
    hs0 = hs_count;
    ready_pat.push_back(1'b1);
    ready_pat.push_back(1'b1); ready_pat.push_back(1'b0); ready_pat.push_back(1'b0);
    ready_pat.push_back(1'b1); ready_pat.push_back(1'b0); ready_pat.push_back(1'b1);
    ready_pat.push_back(1'b1);
    push_beats(32'h3000, 1'b0, 128'h0);
    push_rdata(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    push_rsp(2'd3, 128'h000000B3_000000B2_000000B1_000000B0);
    do_req(32'h3000, MEM_LD_LINE, 2'd3, 128'h0, lat);
    check(hs_count - hs0 == 4, "stall_handshakes", hs_count - hs0, 4);

    push_beats(32'h4010, 1'b0, 128'h0);
    push_rdata(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    push_rsp(2'd0, 128'h000000C3_000000C2_000000C1_000000C0);
    do_req(32'h4010, MEM_LD_LINE, 2'd0, 128'h0, lat);
    check(lat == 6, "lat_b2b_first", lat, 6);
    push_beats(32'h5000, 1'b0, 128'h0);
    push_rdata(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    push_rsp(2'd1, 128'h000000D3_000000D2_000000D1_000000D0);
    do_req(32'h5000, MEM_LD_LINE, 2'd1, 128'h0, lat);
    check(lat == 6, "lat_b2b_second", lat, 6);

    push_rsp(2'd1, 128'h0);
    do_req(32'h8000, 4'd1, 2'd1, 128'h0, lat);
    check(lat == 1, "lat_bad_opcode", lat, 1);

    repeat (5) @(negedge clk);
    check(exp_beats.size() == 0, "beats_left", exp_beats.size(), 0);
    check(exp_rsps.size() == 0, "rsps_left", exp_rsps.size(), 0);
`ifdef MEM_SER_PERF_EN
    check(perf_ld == 64'(n_ld), "perf_ld_lines", perf_ld, n_ld);
    check(perf_st == 64'(n_st), "perf_st_lines", perf_st, n_st);
    check(perf_busy == 64'(busy_exp), "perf_busy_cycles", perf_busy, busy_exp);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
